// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam int REG_ADDR_W      = 5;
    localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is about to write.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    // x0 is hardwired to zero, so a load into it can never create a dependency
    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, redirect and multi-cycle memory hazards.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush/load-use event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  mem_mem_read,
    input  logic                  mem_mem_write,
    input  logic                  mem_branch_taken,
    input  logic                  mem_jal,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  pc_redirect,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  flush_mem_wb,
    output logic                  mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events,
    output logic [31:0]           perf_loaduse_events
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             lu_hazard, memop, redirect, lu_stall, hold_all, req;

    load_use_detect u_lud (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (lu_hazard)
    );

    assign memop = mem_mem_read | mem_mem_write;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        redirect   = 1'b0;
        lu_stall   = 1'b0;
        hold_all   = 1'b0;
        req        = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (memop) begin
                        req        = 1'b1;
                        hold_all   = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = CNT_W'(1);
                    end else if (mem_branch_taken | mem_jal) begin
                        redirect = 1'b1;
                    end else begin
                        lu_stall = lu_hazard;
                    end
                end
                MEM_WAIT: begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        hold_all = 1'b1;
                        if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                            state_d   = HALT;
                            timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                HALT:    hold_all = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Reset drives NOPs into every pipeline register; the decode paths above are already idle
    assign dmem_req     = req;
    assign pc_redirect  = redirect;
    assign stall_pc     = hold_all | lu_stall;
    assign stall_if_id  = hold_all | lu_stall;
    assign stall_id_ex  = hold_all;
    assign stall_ex_mem = hold_all;
    assign flush_if_id  = reset | redirect;
    assign flush_id_ex  = reset | redirect | lu_stall;
    assign flush_ex_mem = reset | redirect;
    assign flush_mem_wb = reset | hold_all;
    assign mem_timeout  = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_lu_q, perf_lu_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_pc & ~&perf_stall_q};
        perf_flush_d = perf_flush_q + {31'd0, redirect & ~&perf_flush_q};
        perf_lu_d    = perf_lu_q + {31'd0, lu_stall & ~&perf_lu_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_lu_q    <= perf_lu_d;
        end
    end

    assign perf_stall_cycles   = perf_stall_q;
    assign perf_flush_events   = perf_flush_q;
    assign perf_loaduse_events = perf_lu_q;
`endif

endmodule
